// File: rtl/stim_pattern_gen.sv
// Stimulus sequencer: sweeps a WIDTH-bit pattern space in one of four
// orderings and holds each pattern for STEP_CYCLES cycles before offering
// it on a valid/ready handshake. Supports one-shot and continuous sweeps.
module stim_pattern_gen #(
  parameter int WIDTH       = 5,
  parameter int STEP_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic             i_one_shot,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_pattern,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap
);

  // The dwell counter needs at least one bit even when STEP_CYCLES is 1.
  localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0]    DWELL_MAX = DW'(STEP_CYCLES - 1);
  // The index runs to all-ones for the counting modes and to WIDTH-1 for the
  // walking-one mode; a WIDTH-bit register covers both ranges.
  localparam logic [WIDTH-1:0] LAST_BIN  = '1;
  localparam logic [WIDTH-1:0] LAST_WALK = WIDTH'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] index;
  logic [WIDTH-1:0] index_next;
  logic [DW-1:0]    dwell;
  logic [DW-1:0]    dwell_next;
  logic [1:0]       mode_q;
  logic [1:0]       mode_next;
  logic             one_shot_q;
  logic             one_shot_next;
  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] pattern_next;
  logic             wrap_q;
  logic             wrap_next;
  logic             start_ok;
  logic             dwell_full;
  logic             transfer;
  logic             at_last;

  // Translate a sweep index into the pattern shown for the given mode.
  function automatic logic [WIDTH-1:0] map_pattern(input logic [WIDTH-1:0] idx,
                                                   input logic [1:0]       mode);
    logic [WIDTH-1:0] pat;
    case (mode)
      2'd0:    pat = idx;
      2'd1:    pat = idx ^ (idx >> 1);
      2'd2:    pat = WIDTH'(1) << idx;
      default: pat = ~idx;
    endcase
    return pat;
  endfunction

  // Handshake and sweep-position qualifiers shared by FSM and datapath.
  always_comb begin
    start_ok   = i_start && ((state == IDLE) || (state == DONE));
    dwell_full = (dwell == DWELL_MAX);
    transfer   = (state == RUN) && dwell_full && i_ready;
    at_last    = (index == ((mode_q == 2'd2) ? LAST_WALK : LAST_BIN));
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a stop always wins over a start or a transfer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!i_stop && i_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (i_stop) begin
          state_next = IDLE;
        end else if (transfer && at_last && one_shot_q) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_stop) begin
          state_next = IDLE;
        end else if (i_start) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state and dwell counter.
  always_comb begin
    o_valid   = (state == RUN) && dwell_full;
    o_busy    = (state == RUN);
    o_done    = (state == DONE);
    o_pattern = pattern_q;
    o_wrap    = wrap_q;
  end

  // Next values for index, dwell, latched configuration and shown pattern.
  always_comb begin
    index_next    = index;
    dwell_next    = dwell;
    mode_next     = mode_q;
    one_shot_next = one_shot_q;
    wrap_next     = 1'b0;
    if (!i_stop && start_ok) begin
      mode_next     = i_mode;
      one_shot_next = i_one_shot;
      index_next    = '0;
      dwell_next    = '0;
    end else if (!i_stop && (state == RUN)) begin
      if (transfer) begin
        dwell_next = '0;
        if (at_last) begin
          wrap_next = 1'b1;
          if (!one_shot_q) begin
            index_next = '0;
          end
        end else begin
          index_next = index + WIDTH'(1);
        end
      end else if (!dwell_full) begin
        dwell_next = dwell + DW'(1);
      end
    end
    pattern_next = pattern_q;
    if (state_next == RUN) begin
      pattern_next = map_pattern(index_next, mode_next);
    end
  end

  // Datapath registers; the pattern register keeps its value outside RUN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      index      <= '0;
      dwell      <= '0;
      mode_q     <= 2'd0;
      one_shot_q <= 1'b0;
      pattern_q  <= '0;
      wrap_q     <= 1'b0;
    end else begin
      index      <= index_next;
      dwell      <= dwell_next;
      mode_q     <= mode_next;
      one_shot_q <= one_shot_next;
      pattern_q  <= pattern_next;
      wrap_q     <= wrap_next;
    end
  end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Self-checking bench for stim_pattern_gen with WIDTH=5, STEP_CYCLES=2.
module tb_stim_pattern_gen;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic       i_one_shot = 1'b0;
  logic       i_ready = 1'b0;
  logic [4:0] o_pattern;
  logic       o_valid;
  logic       o_busy;
  logic       o_done;
  logic       o_wrap;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       one_shot;
    logic       ready;
    logic [4:0] pat;
    logic       valid;
    logic       busy;
    logic       done;
    logic       wrap;
  } vec_t;

  vec_t vecs[18];

  stim_pattern_gen #(.WIDTH(5), .STEP_CYCLES(2)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_mode     (i_mode),
    .i_one_shot (i_one_shot),
    .i_ready    (i_ready),
    .o_pattern  (o_pattern),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_wrap     (o_wrap)
  );

  // Free-running 10-unit clock.
  always #5 i_clk = ~i_clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of inputs, then sample 1 unit after the rising edge.
  task automatic applyStimulus(input logic start, input logic stop, input logic [1:0] mode,
                               input logic one_shot, input logic ready);
    i_start    = start;
    i_stop     = stop;
    i_mode     = mode;
    i_one_shot = one_shot;
    i_ready    = ready;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  // Compare every output against the expected values.
  task automatic checkOutput(input string name, input logic [4:0] exp_pat, input logic exp_valid,
                             input logic exp_busy, input logic exp_done, input logic exp_wrap);
    checks++;
    if ({o_pattern, o_valid, o_busy, o_done, o_wrap} !==
        {exp_pat, exp_valid, exp_busy, exp_done, exp_wrap}) begin
      errors++;
      $display("[TB] FAIL %s: got pat=%0d v=%b b=%b d=%b w=%b, expected pat=%0d v=%b b=%b d=%b w=%b",
               name, o_pattern, o_valid, o_busy, o_done, o_wrap,
               exp_pat, exp_valid, exp_busy, exp_done, exp_wrap);
    end
  endtask

  initial begin
    logic [4:0] prev;
    logic [4:0] gray;

    // Mode3 sweep with backpressure on 28, then ignored mid-run config change.
    vecs[0]  = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd30, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd29, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd29, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd28, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd27, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd27, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd26, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 5'd26, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, then idle after release without a start.
    #2;
    checkOutput("reset_hold", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("idle_after_reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Binary up, one-shot: each pattern held two cycles, done after 64.
    $display("[TB] mode0 one-shot sweep");
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 64; k++) begin
      checkOutput("mode0_sweep", 5'(k / 2), 1'(k % 2), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    end
    checkOutput("mode0_done_wrap", 5'd31, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("mode0_done_hold", 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gray code, one-shot, started from DONE.
    $display("[TB] mode1 one-shot sweep");
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    prev = 5'd0;
    for (int k = 0; k < 64; k++) begin
      gray = 5'(k / 2) ^ (5'(k / 2) >> 1);
      checkOutput("mode1_sweep", gray, 1'(k % 2), 1'b1, 1'b0, 1'b0);
      if ((k % 2 == 0) && (k > 0)) begin
        checks++;
        if ($countones(prev ^ o_pattern) != 1) begin
          errors++;
          $display("[TB] FAIL mode1_one_bit: got %b after %b, expected a single-bit change",
                   o_pattern, prev);
        end
      end
      prev = o_pattern;
      applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    end
    checkOutput("mode1_final", 5'd16, 1'b0, 1'b0, 1'b1, 1'b1);

    // Walking one, continuous: wrap every 10 cycles, never done.
    $display("[TB] mode2 continuous sweep");
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) begin
      checkOutput("mode2_sweep", 5'd1 << ((k / 2) % 5), 1'(k % 2), 1'b1, 1'b0,
                  1'((k > 0) && (k % 10 == 0)));
      if (k < 29) begin
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
      end
    end
    // Stop lands on the last pattern while a transfer is offered.
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    checkOutput("stop_beats_wrap", 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);

    // Table-driven binary-down sweep with backpressure.
    $display("[TB] mode3 table vectors");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].one_shot, vecs[i].ready);
      checkOutput($sformatf("mode3_vec%0d", i), vecs[i].pat, vecs[i].valid, vecs[i].busy,
                  vecs[i].done, vecs[i].wrap);
    end

    // Stop and start together at pattern 7: stop wins, pattern holds.
    $display("[TB] stop and restart");
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    end
    checkOutput("pre_stop_7", 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    checkOutput("stop_start_same", 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("idle_hold", 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("restart_zero", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a sweep at pattern 12.
    $display("[TB] async reset mid-run");
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    end
    checkOutput("pre_reset_12", 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("async_reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("post_reset_idle1", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("post_reset_idle2", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("post_reset_start", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("post_reset_valid", 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("post_reset_next", 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
